// File: rtl/cache_sa.sv
// cache_sa: write-back, write-allocate, set-associative cache with tree-PLRU replacement.
// Optional macro CACHE_PERF_EN builds the hit/miss/writeback performance counters.
`default_nettype none

module cache_sa #(
    parameter int WAYS      = 2,
    parameter int SETS      = 8,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_byte_enable,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [31:0]          pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
    output logic [31:0]          wb_count
);
    localparam int OFS = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - OFS - IDX;
    localparam int LG  = $clog2(WAYS);
    localparam int WW  = (WAYS > 1) ? LG : 1;
    localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_t;
    state_t state;

    logic [31:2]    req_addr;
    logic [31:0]    req_wdata;
    logic [3:0]     req_be;
    logic           req_write;
    logic           first_pass;
    logic [WW-1:0]  victim_q;

    logic [LINE_BITS-1:0] data_arr [WAYS][SETS];
    logic [TAG-1:0]       tag_arr  [WAYS][SETS];
    logic [WAYS-1:0]      valid    [SETS];
    logic [WAYS-1:0]      dirty    [SETS];
    logic [PW-1:0]        plru     [SETS];

    logic [TAG-1:0]  req_tag;
    logic [IDX-1:0]  req_idx;
    logic [OFS-3:0]  req_word;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic            inv_found;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   victim;
    logic [LINE_BITS-1:0] hit_line;
    logic            unused_addr_bits;

    assign req_tag  = req_addr[31:OFS+IDX];
    assign req_idx  = req_addr[OFS+IDX-1:OFS];
    assign req_word = req_addr[OFS-1:2];
    assign unused_addr_bits = ^mem_address[1:0];

    // Each tree node bit points toward the less recently used subtree.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] t);
        int n, w;
        n = 0;
        w = 0;
        for (int l = 0; l < LG; l++) begin
            w = w * 2 + int'(t[n]);
            n = 2 * n + 1 + int'(t[n]);
        end
        return WW'(w);
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WW-1:0] way);
        int n, b;
        logic [PW-1:0] r;
        r = t;
        n = 0;
        for (int l = 0; l < LG; l++) begin
            b    = (int'(way) >> (LG - 1 - l)) & 1;
            r[n] = (b == 0);
            n    = 2 * n + 1 + b;
        end
        return r;
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[req_idx][w] && tag_arr[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru[req_idx]);
    end

    assign hit_line   = data_arr[hit_way][req_idx];
    assign mem_resp   = (state == COMPARE) && hit;
    assign mem_rdata  = mem_resp ? hit_line[{req_word, 5'b00000} +: 32] : 32'h0;
    assign pmem_wdata = data_arr[victim_q][req_idx];

    // Storage arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_write) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b])
                    data_arr[hit_way][req_idx][int'({req_word, 5'b00000}) + 8 * b +: 8] <= req_wdata[8*b +: 8];
            end
        end
        if (state == FILL && pmem_resp) begin
            data_arr[victim_q][req_idx] <= pmem_rdata;
            tag_arr[victim_q][req_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_be       <= '0;
            req_write    <= 1'b0;
            first_pass   <= 1'b0;
            victim_q     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_addr   <= mem_address[31:2];
                        req_wdata  <= mem_wdata;
                        req_be     <= mem_byte_enable;
                        req_write  <= mem_write;
                        first_pass <= 1'b1;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        plru[req_idx] <= plru_touch(plru[req_idx], hit_way);
                        if (req_write && req_be != 4'b0000)
                            dirty[req_idx][hit_way] <= 1'b1;
                        state <= IDLE;
                    end else begin
                        victim_q <= victim;
                        if (valid[req_idx][victim] && dirty[req_idx][victim]) begin
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_arr[victim][req_idx], req_idx, {OFS{1'b0}}};
                            state        <= WB;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, req_idx, {OFS{1'b0}}};
                            state        <= FILL;
                        end
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        pmem_write               <= 1'b0;
                        pmem_read                <= 1'b1;
                        pmem_address             <= {req_tag, req_idx, {OFS{1'b0}}};
                        dirty[req_idx][victim_q] <= 1'b0;
                        state                    <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read                <= 1'b0;
                        valid[req_idx][victim_q] <= 1'b1;
                        dirty[req_idx][victim_q] <= 1'b0;
                        first_pass               <= 1'b0;
                        state                    <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == COMPARE && hit && first_pass)
                hit_count <= hit_count + 32'd1;
            if (state == COMPARE && !hit)
                miss_count <= miss_count + 32'd1;
            if (state == WB && pmem_resp)
                wb_count <= wb_count + 32'd1;
        end
    end
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
    assign wb_count   = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_sa.sv
// Directed self-checking bench for cache_sa at default parameters with a behavioural line memory.
`default_nettype none

module tb_cache_sa;
    logic         clk;
    logic         rst_n;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;

`ifdef CACHE_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    int total = 0;
    int bad   = 0;

    logic [255:0] mem [bit [31:0]];
    int           n_rd, n_wr, dly;
    logic [31:0]  last_rd_addr, last_wr_word1;
    bit           ev_is_wr[$];
    logic [31:0]  ev_addr[$];
    bit           hold;
    bit           both_seen;

    cache_sa dut (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched lines hold word i = line address + 4*i + 8.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(4 * i) + 32'd8;
        return l;
    endfunction

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        dly        = 0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                dly       = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !hold) begin
                dly++;
                if (dly >= 2) begin
                    dly       = 0;
                    pmem_resp = 1'b1;
                    ev_is_wr.push_back(pmem_write);
                    ev_addr.push_back(pmem_address);
                    if (pmem_write) begin
                        mem[pmem_address] = pmem_wdata;
                        last_wr_word1     = pmem_wdata[63:32];
                        n_wr++;
                    end else begin
                        pmem_rdata   = line_of(pmem_address);
                        last_rd_addr = pmem_address;
                        n_rd++;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic clear_log();
        n_rd = 0;
        n_wr = 0;
        ev_is_wr.delete();
        ev_addr.delete();
        both_seen = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem.delete();
        clear_log();
    endtask

    // cyc counts clock cycles the request is held, including the mem_resp cycle.
    task automatic do_req(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output int cyc);
        int  n;
        bit  done;
        rd = '0;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        mem_address = a; mem_write = wr; mem_read = !wr;
        mem_wdata = wd; mem_byte_enable = be;
        while (!done && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_resp) begin
                rd   = mem_rdata;
                done = 1'b1;
            end
        end
        cyc = n + 1;
        if (!done) begin
            total++; bad++;
            $display("FAIL req_timeout addr=%h got no mem_resp want mem_resp", a);
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL rst_mem_resp got %b want 0", mem_resp); end
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL rst_pmem_read got %b want 0", pmem_read); end
        total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL rst_pmem_write got %b want 0", pmem_write); end
        total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL rst_pmem_address got %h want 0", pmem_address); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL rst_mem_rdata got %h want 0", mem_rdata); end
        total++; if ({hit_count, miss_count, wb_count} !== 96'h0) begin bad++;
            $display("FAIL rst_counters got %h/%h/%h want 0", hit_count, miss_count, wb_count); end
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int cyc;
        do_req(32'h0000_0000, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL cold_rdata got %h want 00000008", rd); end
        total++; if (n_rd !== 1 || last_rd_addr !== 32'h0) begin bad++;
            $display("FAIL cold_fill got %0d reads @%h want 1 read @00000000", n_rd, last_rd_addr); end
        total++; if (n_wr !== 0) begin bad++; $display("FAIL cold_no_wb got %0d want 0", n_wr); end
        total++; if (miss_count !== 32'(PERF) || hit_count !== 32'h0) begin bad++;
            $display("FAIL cold_counters got miss=%0d hit=%0d want miss=%0d hit=0", miss_count, hit_count, PERF); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc;
        apply_reset();
        do_req(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, cyc);
        total++; if (n_rd !== 1 || n_wr !== 0) begin bad++;
            $display("FAIL wr_alloc got rd=%0d wr=%0d want rd=1 wr=0", n_rd, n_wr); end
        do_req(32'h0000_0004, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_readback got %h want deadbeef", rd); end
        total++; if (cyc !== 2) begin bad++; $display("FAIL hit_latency got %0d want 2", cyc); end
        total++; if (n_rd !== 1) begin bad++; $display("FAIL hit_no_fill got %0d reads want 1", n_rd); end
        total++; if (hit_count !== 32'(PERF) || miss_count !== 32'(PERF)) begin bad++;
            $display("FAIL wr_counters got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, PERF, PERF); end
    endtask

    task automatic test_evict();
        logic [31:0] rd; int cyc;
        clear_log();
        do_req(32'hDEED_EE00, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (n_rd !== 1 || n_wr !== 0 || last_rd_addr !== 32'hDEED_EE00) begin bad++;
            $display("FAIL way1_fill got rd=%0d wr=%0d @%h want rd=1 wr=0 @deedee00", n_rd, n_wr, last_rd_addr); end
        total++; if (rd !== 32'hDEED_EE08) begin bad++; $display("FAIL way1_rdata got %h want deedee08", rd); end
        clear_log();
        do_req(32'h6666_6600, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (ev_is_wr.size() !== 2 || ev_is_wr[0] !== 1'b1 || ev_addr[0] !== 32'h0) begin bad++;
            $display("FAIL wb_first got n=%0d first_is_wr=%b @%h want 2 wr @00000000",
                     ev_is_wr.size(), ev_is_wr[0], ev_addr[0]); end
        total++; if (last_wr_word1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wb_data got %h want deadbeef", last_wr_word1); end
        total++; if (ev_is_wr[1] !== 1'b0 || ev_addr[1] !== 32'h6666_6600) begin bad++;
            $display("FAIL wb_then_fill got is_wr=%b @%h want rd @66666600", ev_is_wr[1], ev_addr[1]); end
        total++; if (rd !== 32'h6666_6608) begin bad++; $display("FAIL evict_rdata got %h want 66666608", rd); end
        total++; if (wb_count !== 32'(PERF)) begin bad++; $display("FAIL wb_counter got %0d want %0d", wb_count, PERF); end
        total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL strobe_excl got both high want never"); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; int cyc;
        apply_reset();
        do_req(32'h0000_0020, 1'b1, 32'hAAAA_AAAA, 4'hF, rd, cyc);
        do_req(32'h0000_0020, 1'b1, 32'h1234_5678, 4'h3, rd, cyc);
        do_req(32'h0000_0020, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (rd !== 32'hAAAA_5678) begin bad++; $display("FAIL byte_merge got %h want aaaa5678", rd); end
        clear_log();
        do_req(32'h0000_0040, 1'b0, 32'h0, 4'h0, rd, cyc);
        do_req(32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, cyc);
        do_req(32'h0000_0040, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (rd !== 32'h0000_0048) begin bad++; $display("FAIL be0_data got %h want 00000048", rd); end
        do_req(32'h0000_1040, 1'b0, 32'h0, 4'h0, rd, cyc);
        do_req(32'h0000_2040, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (n_wr !== 0 || n_rd !== 3) begin bad++;
            $display("FAIL be0_clean got wr=%0d rd=%0d want wr=0 rd=3", n_wr, n_rd); end
        total++; if (rd !== 32'h0000_2048) begin bad++; $display("FAIL plru_fill got %h want 00002048", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [31:0] last;
        pulses = 0;
        last = '0;
        @(negedge clk);
        mem_address = 32'h0000_0020; mem_read = 1'b1; mem_write = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                pulses++;
                last = mem_rdata;
            end
        end
        @(negedge clk);
        mem_read = 1'b0;
        total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
        total++; if (last !== 32'hAAAA_5678) begin bad++; $display("FAIL b2b_rdata got %h want aaaa5678", last); end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] rd; int cyc, n;
        apply_reset();
        do_req(32'h0000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, rd, cyc);
        do_req(32'h0000_1000, 1'b0, 32'h0, 4'h0, rd, cyc);
        hold = 1'b1;
        @(negedge clk);
        mem_address = 32'h0000_2000; mem_read = 1'b1; mem_write = 1'b0;
        n = 0;
        while (!pmem_write && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (pmem_write !== 1'b1) begin bad++; $display("FAIL wb_entry got %b want 1", pmem_write); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin bad++;
            $display("FAIL async_drop got wr=%b rd=%b want 0/0", pmem_write, pmem_read); end
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        clear_log();
        do_req(32'h0000_0000, 1'b0, 32'h0, 4'h0, rd, cyc);
        total++; if (n_rd !== 1) begin bad++; $display("FAIL post_rst_miss got %0d reads want 1", n_rd); end
        total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL post_rst_data got %h want 00000008", rd); end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = '0; mem_byte_enable = '0;
        hold = 1'b0;
        both_seen = 1'b0;
        n_rd = 0; n_wr = 0;
        last_rd_addr = '0; last_wr_word1 = '0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_evict();
        test_byte_merge();
        test_back_to_back();
        test_reset_mid_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
